// File: rtl/ni_local_tx.sv
`default_nettype none
// ============================================================================
// ni_local_tx : PE-to-router Local-port injector (header/body/tail flits, even parity)
// Rev 1.0
// ============================================================================
module ni_local_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4,
  parameter int PID_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS-1:0]       cur_addr,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [AXIS-1:0]       pkt_dst,
  input  logic [11:0]           pkt_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [27:0]           pl_data,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  RTS,
  input  logic                  CTS,
  output logic                  pkt_done,
  output logic [PID_WIDTH-1:0]  pkt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAD  = 2'd1,
    FETCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic                 flit_valid, flit_valid_nx;
  logic                 last, last_nx;
  logic [11:0]          rem, rem_nx;
  logic [31:0]          tx_q, tx_nx;
  logic [PID_WIDTH-1:0] pid, pid_nx;
  logic [11:0]          len_p;
  logic                 xfer;

  // Bit 0 makes the XOR over the whole flit zero.
  function automatic logic [31:0] with_parity(input logic [31:0] f);
    return {f[31:1], ^f[31:1]};
  endfunction

  function automatic logic [31:0] payload_flit(input logic is_tail, input logic [27:0] d);
    return with_parity({(is_tail ? 3'b100 : 3'b010), d, 1'b0});
  endfunction

  assign len_p     = (pkt_len < 12'd2) ? 12'd2 : pkt_len;
  assign xfer      = flit_valid & CTS;
  assign RTS       = xfer;
  assign TX        = DATA_WIDTH'(tx_q);
  assign pkt_id    = pid;
  assign pkt_ready = rst & (state == IDLE);

  always_comb begin
    state_nx      = state;
    flit_valid_nx = flit_valid;
    last_nx       = last;
    rem_nx        = rem;
    tx_nx         = tx_q;
    pid_nx        = pid;
    pl_ready      = 1'b0;
    pkt_done      = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_valid) begin
          tx_nx         = with_parity({3'b001, len_p, 4'(pkt_dst), 4'(cur_addr), 8'(pid), 1'b0});
          flit_valid_nx = 1'b1;
          last_nx       = 1'b0;
          rem_nx        = len_p - 12'd1;
          state_nx      = HEAD;
        end
      end
      HEAD: begin
        if (xfer) begin
          flit_valid_nx = 1'b0;
          state_nx      = FETCH;
        end
      end
      FETCH: begin
        pl_ready = 1'b1;
        if (pl_valid) begin
          tx_nx         = payload_flit(rem == 12'd1, pl_data);
          last_nx       = (rem == 12'd1);
          flit_valid_nx = 1'b1;
          state_nx      = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          rem_nx = rem - 12'd1;
          if (last) begin
            pkt_done      = 1'b1;
            pid_nx        = pid + 1'b1;
            flit_valid_nx = 1'b0;
            last_nx       = 1'b0;
            state_nx      = IDLE;
          end else begin
            // Overlap: the outgoing flit frees TX, so the next word can load on the same edge.
            pl_ready = 1'b1;
            if (pl_valid) begin
              tx_nx   = payload_flit(rem == 12'd2, pl_data);
              last_nx = (rem == 12'd2);
            end else begin
              flit_valid_nx = 1'b0;
              state_nx      = FETCH;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      flit_valid <= 1'b0;
      last       <= 1'b0;
      rem        <= 12'd0;
      tx_q       <= 32'd0;
      pid        <= '0;
    end else begin
      state      <= state_nx;
      flit_valid <= flit_valid_nx;
      last       <= last_nx;
      rem        <= rem_nx;
      tx_q       <= tx_nx;
      pid        <= pid_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ni_local_tx.sv
`default_nettype none
// ============================================================================
// tb_ni_local_tx : scoreboard + vector-table bench for ni_local_tx
// Rev 1.0
// ============================================================================
module tb_ni_local_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cur_addr;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_dst;
  logic [11:0] pkt_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [27:0] pl_data;
  logic [31:0] TX;
  logic        RTS;
  logic        CTS;
  logic        pkt_done;
  logic [7:0]  pkt_id;

  always #5 clk = ~clk;

  ni_local_tx #(.DATA_WIDTH(32), .AXIS(4), .PID_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cur_addr(cur_addr),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .TX(TX), .RTS(RTS), .CTS(CTS), .pkt_done(pkt_done), .pkt_id(pkt_id)
  );

  typedef struct {
    logic [31:0] flit;
    bit          tail;
    bit          hdr;
  } exp_t;

  typedef struct {
    logic [11:0] len;
    logic [3:0]  dst;
    logic [3:0]  addr;
    bit          gaps;
    int          exp_flits;
    logic [11:0] exp_hlen;
  } vec_t;

  exp_t        exp_q[$];
  logic [27:0] pay_q[$];
  int          xfer_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          req_cyc = 0;
  logic [31:0] last_hdr = '0;
  logic [7:0]  exp_id = '0;
  bit          gaps = 1'b0;
  bit          acc = 1'b0;

  function automatic logic [31:0] par(input logic [31:0] f);
    logic [31:0] r;
    r = f & 32'hFFFF_FFFE;
    if (^r) r = r | 32'd1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every flit the router would take is compared with the next expected one.
  always @(negedge clk) begin
    exp_t e;
    acc = pl_valid & pl_ready;
    if (rst) begin
      if (pkt_done) done_cnt++;
      if (RTS) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        chk("flit_parity", 64'(^TX), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got %h expected no flit", TX);
        end else begin
          e = exp_q.pop_front();
          chk("flit", 64'(TX), 64'(e.flit));
          chk("pkt_done_on_tail", 64'(pkt_done), 64'(e.tail));
          if (e.hdr) last_hdr = TX;
        end
      end else if (pkt_done) begin
        chk("pkt_done_without_xfer", 64'(pkt_done), 64'd0);
      end
    end
  end

  // Payload source: presents queued words, optionally with random idle cycles.
  initial begin
    pl_valid = 1'b0;
    pl_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acc && pay_q.size() > 0) pay_q.delete(0);
      if (pay_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        pl_valid = 1'b1;
        pl_data  = pay_q[0];
      end else begin
        pl_valid = 1'b0;
      end
    end
  end

  task automatic send_pkt(input logic [11:0] len, input logic [3:0] dst, input logic [27:0] base);
    int          n;
    int          waited;
    logic [27:0] d;
    n = (len < 12'd2) ? 2 : int'(len);
    exp_q.push_back('{par({3'b001, 12'(n), dst, cur_addr, exp_id, 1'b0}), 1'b0, 1'b1});
    for (int i = 1; i < n; i++) begin
      d = base + 28'(i);
      pay_q.push_back(d);
      exp_q.push_back('{par({((i == n - 1) ? 3'b100 : 3'b010), d, 1'b0}), (i == n - 1), 1'b0});
    end
    pkt_len   = len;
    pkt_dst   = dst;
    pkt_valid = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (pkt_ready) break;
      waited++;
      if (waited > 2000) begin
        checks++;
        errors++;
        $display("FAIL pkt_ready_timeout: got no pkt_ready expected within 2000 cycles");
        break;
      end
    end
    req_cyc = cyc;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    exp_id++;
  endtask

  task automatic wait_done(input int target);
    int w;
    w = 0;
    while (done_cnt < target && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL pkt_done_timeout: got %0d packets expected %0d", done_cnt, target);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int f0, d0, w;
    logic [31:0] hold;
    logic [7:0]  id0;

    vecs[0] = '{12'd0,  4'd5,  4'd1,  1'b0, 2,  12'd2};
    vecs[1] = '{12'd1,  4'd9,  4'd2,  1'b1, 2,  12'd2};
    vecs[2] = '{12'd2,  4'd15, 4'd3,  1'b0, 2,  12'd2};
    vecs[3] = '{12'd3,  4'd3,  4'd0,  1'b1, 3,  12'd3};
    vecs[4] = '{12'd5,  4'd7,  4'd14, 1'b1, 5,  12'd5};
    vecs[5] = '{12'd20, 4'd1,  4'd6,  1'b1, 20, 12'd20};

    rst = 1'b0; CTS = 1'b1; cur_addr = '0; pkt_valid = 1'b0; pkt_dst = '0; pkt_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_TX", 64'(TX), 64'd0);
    chk("rst_RTS", 64'(RTS), 64'd0);
    chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("rst_pl_ready", 64'(pl_ready), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_pkt_id", 64'(pkt_id), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_pkt_ready", 64'(pkt_ready), 64'd1);
    @(posedge clk); #1;

    // Basic packet: dst 3, len 3, payload 1 and 2
    xfer_cyc.delete();
    send_pkt(12'd3, 4'd3, 28'd0);
    wait_done(1);
    chk("t1_header", 64'(last_hdr), 64'h20066001);
    chk("t1_pkt_id", 64'(pkt_id), 64'd1);
    chk("t1_done_count", 64'(done_cnt), 64'd1);
    chk("t1_first_rts_latency", 64'(xfer_cyc[0] - req_cyc), 64'd1);

    // Table-driven packets
    foreach (vecs[k]) begin
      cur_addr = vecs[k].addr;
      gaps     = vecs[k].gaps;
      f0 = xfer_cnt;
      d0 = done_cnt;
      send_pkt(vecs[k].len, vecs[k].dst, 28'($urandom));
      wait_done(d0 + 1);
      chk("vec_flit_count", 64'(xfer_cnt - f0), 64'(vecs[k].exp_flits));
      chk("vec_hdr_len", 64'(last_hdr[28:17]), 64'(vecs[k].exp_hlen));
      chk("vec_hdr_dst", 64'(last_hdr[16:13]), 64'(vecs[k].dst));
      chk("vec_hdr_src", 64'(last_hdr[12:9]), 64'(vecs[k].addr));
      chk("vec_pkt_id", 64'(pkt_id), 64'(exp_id));
    end
    gaps = 1'b0;
    cur_addr = 4'd0;

    // CTS low for 5 cycles while a body flit is pending
    d0 = done_cnt;
    send_pkt(12'd3, 4'd3, 28'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    CTS  = 1'b0;
    hold = TX;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_RTS", 64'(RTS), 64'd0);
      chk("stall_TX_held", 64'(TX), 64'(hold));
      chk("stall_pl_ready", 64'(pl_ready), 64'd0);
      @(posedge clk); #1;
    end
    CTS = 1'b1;
    wait_done(d0 + 1);

    // 256 back-to-back minimal packets: pkt_id wraps around
    d0  = done_cnt;
    id0 = pkt_id;
    for (int i = 0; i < 256; i++) send_pkt(12'd2, 4'(i), 28'($urandom));
    wait_done(d0 + 256);
    chk("wrap_pkt_id", 64'(pkt_id), 64'(id0));
    chk("wrap_done_count", 64'(done_cnt - d0), 64'd256);

    // Streaming payload: 7 payload flits on consecutive cycles
    xfer_cyc.delete();
    d0 = done_cnt;
    send_pkt(12'd8, 4'd2, 28'($urandom));
    wait_done(d0 + 1);
    chk("stream_flits", 64'(xfer_cyc.size()), 64'd8);
    if (xfer_cyc.size() == 8) begin
      chk("stream_consecutive", 64'(xfer_cyc[7] - xfer_cyc[1]), 64'd6);
      chk("stream_rts_latency", 64'(xfer_cyc[0] - req_cyc), 64'd1);
    end

    // Reset in the middle of a 10-flit packet after header + 2 bodies
    f0 = xfer_cnt;
    send_pkt(12'd10, 4'd6, 28'($urandom));
    w = 0;
    while (xfer_cnt < f0 + 3 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("midrst_flits_before", 64'(xfer_cnt - f0), 64'd3);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_TX", 64'(TX), 64'd0);
    chk("midrst_RTS", 64'(RTS), 64'd0);
    chk("midrst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("midrst_pl_ready", 64'(pl_ready), 64'd0);
    chk("midrst_pkt_done", 64'(pkt_done), 64'd0);
    chk("midrst_pkt_id", 64'(pkt_id), 64'd0);
    exp_q.delete();
    pay_q.delete();
    exp_id = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = done_cnt;
    send_pkt(12'd2, 4'd4, 28'($urandom));
    wait_done(d0 + 1);
    chk("postrst_hdr_type", 64'(last_hdr[31:29]), 64'd1);
    chk("postrst_hdr_pid", 64'(last_hdr[8:1]), 64'd0);
    chk("postrst_pkt_id", 64'(pkt_id), 64'd1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("payload_consumed", 64'(pay_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
